// File: rtl/yaya_butonu_pkg.sv
// Shared types and helpers for the pedestrian push-button front end.
// Holds the press-tracking state encoding and the ms-to-cycles conversion.
package yaya_butonu_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_PRESSED = 2'd1,
        ST_HELD    = 2'd2
    } press_state_t;

    function automatic int unsigned ms_to_cyc(input int unsigned clk_hz, input int unsigned ms);
        return (clk_hz / 32'd1000) * ms;
    endfunction

endpackage

// File: rtl/sinyal_debounce.sv
// Two-flop synchroniser and stable-level debouncer for an asynchronous input.
// The fall/rise strobes are high in the cycle the new level is being accepted.
module sinyal_debounce
    import yaya_butonu_pkg::*;
#(
    parameter int unsigned DEB_CYC = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic din,
    output logic level,
    output logic fall,
    output logic rise
);

    localparam int unsigned CW = $clog2(DEB_CYC + 1);

    logic          sync1_r;
    logic          sync2_r;
    logic          stable_r;
    logic [CW-1:0] cnt_r;
    logic          accept_s;

    // Accept only after DEB_CYC consecutive samples disagree with the stable level.
    always_comb begin
        accept_s = (sync2_r != stable_r) && (cnt_r == CW'(DEB_CYC - 1));
        fall     = accept_s && !sync2_r;
        rise     = accept_s && sync2_r;
        level    = stable_r;
    end

    // Synchroniser chain, idling at the released level.
    always_ff @(posedge clk) begin
        if (rst) begin
            sync1_r <= 1'b1;
            sync2_r <= 1'b1;
        end else begin
            sync1_r <= din;
            sync2_r <= sync1_r;
        end
    end

    // Stability counter and accepted level.
    always_ff @(posedge clk) begin
        if (rst) begin
            stable_r <= 1'b1;
            cnt_r    <= {CW{1'b0}};
        end else if (sync2_r == stable_r) begin
            cnt_r    <= {CW{1'b0}};
        end else if (accept_s) begin
            stable_r <= sync2_r;
            cnt_r    <= {CW{1'b0}};
        end else begin
            cnt_r    <= cnt_r + CW'(1'b1);
        end
    end

endmodule

// File: rtl/yaya_butonu.sv
// Pedestrian push-button front end: short/long press detection, request latch
// held until the controller acknowledges, and a blinking active-low wait LED.
module yaya_butonu
    import yaya_butonu_pkg::*;
#(
    parameter int unsigned CLK_HZ        = 24_000_000,
    parameter int unsigned DEBOUNCE_MS   = 20,
    parameter int unsigned LONG_PRESS_MS = 1000,
    parameter int unsigned BLINK_MS      = 250
) (
    input  logic clk,
    input  logic rst,
    input  logic btn_n,
    input  logic ped_ack,
    output logic ped_req,
    output logic press_pulse,
    output logic long_press,
    output logic wait_led_n
);

    localparam int unsigned DEB_CYC   = ms_to_cyc(CLK_HZ, DEBOUNCE_MS);
    localparam int unsigned LONG_CYC  = ms_to_cyc(CLK_HZ, LONG_PRESS_MS);
    localparam int unsigned BLINK_CYC = ms_to_cyc(CLK_HZ, BLINK_MS);
    localparam int unsigned LW        = $clog2(LONG_CYC + 1);
    localparam int unsigned BW        = $clog2(BLINK_CYC + 1);

    logic          btn_level_s;
    logic          btn_fall_s;
    logic          btn_rise_s;
    press_state_t  state_r;
    press_state_t  state_s;
    logic [LW-1:0] hold_cnt_r;
    logic [LW-1:0] hold_cnt_s;
    logic          press_s;
    logic          long_s;
    logic [BW-1:0] blink_cnt_r;

    sinyal_debounce #(
        .DEB_CYC (DEB_CYC)
    ) u_debounce (
        .clk   (clk),
        .rst   (rst),
        .din   (btn_n),
        .level (btn_level_s),
        .fall  (btn_fall_s),
        .rise  (btn_rise_s)
    );

    // Press FSM next state; a high stable level outside IDLE also forces recovery.
    always_comb begin
        state_s    = state_r;
        hold_cnt_s = hold_cnt_r;
        press_s    = 1'b0;
        long_s     = 1'b0;
        case (state_r)
            ST_IDLE: begin
                hold_cnt_s = {LW{1'b0}};
                if (btn_fall_s) begin
                    state_s = ST_PRESSED;
                    press_s = 1'b1;
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_PRESSED: begin
                if (btn_rise_s || btn_level_s) begin
                    state_s    = ST_IDLE;
                    hold_cnt_s = {LW{1'b0}};
                end else if (hold_cnt_r == LW'(LONG_CYC - 1)) begin
                    state_s    = ST_HELD;
                    long_s     = 1'b1;
                    hold_cnt_s = {LW{1'b0}};
                end else begin
                    hold_cnt_s = hold_cnt_r + LW'(1'b1);
                end
            end
            ST_HELD: begin
                if (btn_rise_s || btn_level_s) begin
                    state_s = ST_IDLE;
                end else begin
                    state_s = ST_HELD;
                end
            end
            default: begin
                state_s    = ST_IDLE;
                hold_cnt_s = {LW{1'b0}};
            end
        endcase
    end

    // FSM state, hold counter and registered press strobes.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r     <= ST_IDLE;
            hold_cnt_r  <= {LW{1'b0}};
            press_pulse <= 1'b0;
            long_press  <= 1'b0;
        end else begin
            state_r     <= state_s;
            hold_cnt_r  <= hold_cnt_s;
            press_pulse <= press_s;
            long_press  <= long_s;
        end
    end

    // Request latch; an acknowledge in the same cycle as a press drops the press.
    always_ff @(posedge clk) begin
        if (rst) begin
            ped_req <= 1'b0;
        end else if (ped_ack) begin
            ped_req <= 1'b0;
        end else if (press_pulse) begin
            ped_req <= 1'b1;
        end else begin
            ped_req <= ped_req;
        end
    end

    // Blink generator: toggles when the phase counter wraps to zero, so the LED lights first.
    always_ff @(posedge clk) begin
        if (rst || !ped_req) begin
            blink_cnt_r <= {BW{1'b0}};
            wait_led_n  <= 1'b1;
        end else begin
            if (blink_cnt_r == {BW{1'b0}}) begin
                wait_led_n <= ~wait_led_n;
            end else begin
                wait_led_n <= wait_led_n;
            end
            if (blink_cnt_r == BW'(BLINK_CYC - 1)) begin
                blink_cnt_r <= {BW{1'b0}};
            end else begin
                blink_cnt_r <= blink_cnt_r + BW'(1'b1);
            end
        end
    end

endmodule

// File: tb/tb_yaya_butonu.sv
// Directed bench for yaya_butonu with DEB_CYC=4, LONG_CYC=10, BLINK_CYC=3.
// Inputs change and outputs are sampled on the falling clock edge.
module tb_yaya_butonu;

    logic clk = 1'b0;
    logic rst;
    logic btn_n;
    logic ped_ack;
    logic ped_req;
    logic press_pulse;
    logic long_press;
    logic wait_led_n;
    int   total = 0;
    int   bad   = 0;

    always #5 clk = ~clk;

    yaya_butonu #(
        .CLK_HZ        (1000),
        .DEBOUNCE_MS   (4),
        .LONG_PRESS_MS (10),
        .BLINK_MS      (3)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .btn_n       (btn_n),
        .ped_ack     (ped_ack),
        .ped_req     (ped_req),
        .press_pulse (press_pulse),
        .long_press  (long_press),
        .wait_led_n  (wait_led_n)
    );

    task automatic test_reset();
        rst = 1'b1; btn_n = 1'b1; ped_ack = 1'b0;
        repeat (3) @(negedge clk);
        total++; if (ped_req !== 1'b0)     begin bad++; $display("FAIL reset_ped_req got=%b exp=0", ped_req); end
        total++; if (press_pulse !== 1'b0) begin bad++; $display("FAIL reset_press got=%b exp=0", press_pulse); end
        total++; if (long_press !== 1'b0)  begin bad++; $display("FAIL reset_long got=%b exp=0", long_press); end
        total++; if (wait_led_n !== 1'b1)  begin bad++; $display("FAIL reset_led got=%b exp=1", wait_led_n); end
        rst = 1'b0;
    endtask

    task automatic test_bounce();
        for (int r = 0; r < 5; r++) begin
            btn_n = 1'b0;
            repeat (3) begin
                @(negedge clk);
                total++; if (press_pulse !== 1'b0) begin bad++; $display("FAIL bounce_press r=%0d got=%b exp=0", r, press_pulse); end
            end
            btn_n = 1'b1;
            @(negedge clk);
            total++; if (press_pulse !== 1'b0) begin bad++; $display("FAIL bounce_press_hi r=%0d got=%b exp=0", r, press_pulse); end
        end
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            total++; if (press_pulse !== 1'b0) begin bad++; $display("FAIL bounce_tail_press i=%0d got=%b exp=0", i, press_pulse); end
            total++; if (ped_req !== 1'b0)     begin bad++; $display("FAIL bounce_ped_req i=%0d got=%b exp=0", i, ped_req); end
        end
    endtask

    // Press held 8 samples: pulse at sample 6, request from 7, LED on from 8, toggling every 3.
    task automatic test_clean_press();
        logic exp_led;
        btn_n = 1'b0;
        for (int i = 1; i <= 20; i++) begin
            @(negedge clk);
            exp_led = (i < 8) ? 1'b1 : ((((i - 8) / 3) % 2 == 0) ? 1'b0 : 1'b1);
            total++; if (press_pulse !== (i == 6)) begin bad++; $display("FAIL clean_press i=%0d got=%b exp=%b", i, press_pulse, (i == 6)); end
            total++; if (ped_req !== (i >= 7))     begin bad++; $display("FAIL clean_ped_req i=%0d got=%b exp=%b", i, ped_req, (i >= 7)); end
            total++; if (long_press !== 1'b0)      begin bad++; $display("FAIL clean_long i=%0d got=%b exp=0", i, long_press); end
            total++; if (wait_led_n !== exp_led)   begin bad++; $display("FAIL blink_led i=%0d got=%b exp=%b", i, wait_led_n, exp_led); end
            if (i == 8) btn_n = 1'b1;
        end
    endtask

    task automatic test_ack();
        ped_ack = 1'b1;
        @(negedge clk);
        ped_ack = 1'b0;
        total++; if (ped_req !== 1'b0)    begin bad++; $display("FAIL ack_ped_req got=%b exp=0", ped_req); end
        total++; if (wait_led_n !== 1'b0) begin bad++; $display("FAIL ack_led_lag got=%b exp=0", wait_led_n); end
        @(negedge clk);
        total++; if (wait_led_n !== 1'b1) begin bad++; $display("FAIL ack_led_off got=%b exp=1", wait_led_n); end
        total++; if (ped_req !== 1'b0)    begin bad++; $display("FAIL ack_ped_req_hold got=%b exp=0", ped_req); end
    endtask

    task automatic test_long_press();
        btn_n = 1'b0;
        for (int i = 1; i <= 30; i++) begin
            @(negedge clk);
            total++; if (press_pulse !== (i == 6)) begin bad++; $display("FAIL long_press_pulse i=%0d got=%b exp=%b", i, press_pulse, (i == 6)); end
            total++; if (long_press !== (i == 16)) begin bad++; $display("FAIL long_pulse i=%0d got=%b exp=%b", i, long_press, (i == 16)); end
            total++; if (ped_req !== (i >= 7))     begin bad++; $display("FAIL long_ped_req i=%0d got=%b exp=%b", i, ped_req, (i >= 7)); end
            if (i == 20) btn_n = 1'b1;
        end
        ped_ack = 1'b1;
        @(negedge clk);
        ped_ack = 1'b0;
        total++; if (ped_req !== 1'b0) begin bad++; $display("FAIL long_ack_ped_req got=%b exp=0", ped_req); end
        @(negedge clk);
    endtask

    // Second press pulse lands in the same cycle as ped_ack: the ack wins.
    task automatic test_ack_collision();
        btn_n = 1'b0;
        for (int i = 1; i <= 34; i++) begin
            @(negedge clk);
            total++; if (press_pulse !== (i == 6 || i == 22))  begin bad++; $display("FAIL coll_press i=%0d got=%b exp=%b", i, press_pulse, (i == 6 || i == 22)); end
            total++; if (ped_req !== (i >= 7 && i <= 22))      begin bad++; $display("FAIL coll_ped_req i=%0d got=%b exp=%b", i, ped_req, (i >= 7 && i <= 22)); end
            total++; if (long_press !== 1'b0)                  begin bad++; $display("FAIL coll_long i=%0d got=%b exp=0", i, long_press); end
            if (i == 8)  btn_n = 1'b1;
            if (i == 16) btn_n = 1'b0;
            if (i == 22) ped_ack = 1'b1;
            if (i == 23) ped_ack = 1'b0;
            if (i == 24) btn_n = 1'b1;
        end
    endtask

    task automatic test_reset_mid_hold();
        btn_n = 1'b0;
        for (int i = 1; i <= 8; i++) begin
            @(negedge clk);
            total++; if (press_pulse !== (i == 6)) begin bad++; $display("FAIL mid_pre_press i=%0d got=%b exp=%b", i, press_pulse, (i == 6)); end
        end
        rst = 1'b1;
        repeat (2) begin
            @(negedge clk);
            total++; if (ped_req !== 1'b0)     begin bad++; $display("FAIL mid_rst_ped_req got=%b exp=0", ped_req); end
            total++; if (press_pulse !== 1'b0) begin bad++; $display("FAIL mid_rst_press got=%b exp=0", press_pulse); end
            total++; if (long_press !== 1'b0)  begin bad++; $display("FAIL mid_rst_long got=%b exp=0", long_press); end
            total++; if (wait_led_n !== 1'b1)  begin bad++; $display("FAIL mid_rst_led got=%b exp=1", wait_led_n); end
        end
        rst = 1'b0;
        for (int j = 1; j <= 10; j++) begin
            @(negedge clk);
            total++; if (press_pulse !== (j == 6)) begin bad++; $display("FAIL mid_post_press j=%0d got=%b exp=%b", j, press_pulse, (j == 6)); end
            total++; if (ped_req !== (j >= 7))     begin bad++; $display("FAIL mid_post_ped_req j=%0d got=%b exp=%b", j, ped_req, (j >= 7)); end
        end
        btn_n = 1'b1;
        repeat (8) @(negedge clk);
        ped_ack = 1'b1;
        @(negedge clk);
        ped_ack = 1'b0;
        total++; if (ped_req !== 1'b0) begin bad++; $display("FAIL mid_final_ped_req got=%b exp=0", ped_req); end
    endtask

    initial begin
        test_reset();
        test_bounce();
        test_clean_press();
        test_ack();
        test_long_press();
        test_ack_collision();
        test_reset_mid_hold();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
